slow_receiver2: RTL

//  Deserialising receiver for the SlowLink2 serial frame, i.e. the far end of SlowTransmitter2.

---
 rtl/slow_receiver2.sv | 118 +++++++++++
 1 files changed

// File: rtl/slow_receiver2.sv
// SlowLink2 serial frame receiver: oversamples the line, checks even parity and the
// stop bit, and publishes each good payload with a one-cycle valid strobe.
module slow_receiver2 #(
   parameter int BIT_DIV   = 5,
   parameter int PAYLOAD_W = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_i,
   output logic [PAYLOAD_W-1:0] payload_o,
   output logic                 valid_o,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic [15:0]          err_count_o,
   output logic                 idle_o
);
   localparam int CW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
   localparam int IW = (PAYLOAD_W > 2) ? $clog2(PAYLOAD_W) : 1;
   localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BIT_DIV / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_W - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

   state_t               state;
   logic                 sync1, rx_s, rx_d;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [PAYLOAD_W-1:0] shreg;
   logic                 par_ok;

   // Presetting to 1 keeps a line that is idle at reset release from looking like a start edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         sync1 <= serial_i;
         rx_s  <= sync1;
         rx_d  <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         par_ok       <= 1'b0;
         payload_o    <= '0;
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
         err_count_o  <= '0;
      end else begin
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_d && !rx_s) begin
                  state <= S_START;
                  cnt   <= CNT_HALF;
               end
            end
            S_START: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else if (!rx_s) begin
                  state <= S_DATA;
                  cnt   <= CNT_BIT;
                  idx   <= '0;
               end else state <= S_IDLE;
            end
            S_DATA: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  shreg <= {shreg[PAYLOAD_W-2:0], rx_s};
                  cnt   <= CNT_BIT;
                  idx   <= idx + 1'b1;
                  if (idx == IDX_LAST) state <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  par_ok <= ((^shreg) ^ rx_s) == 1'b0;
                  cnt    <= CNT_BIT;
                  state  <= S_STOP;
               end
            end
            S_STOP: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else if (!rx_s) begin
                  frame_err_o <= 1'b1;
                  state       <= S_BREAK;
                  if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 1'b1;
               end else if (!par_ok) begin
                  parity_err_o <= 1'b1;
                  state        <= S_IDLE;
                  if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 1'b1;
               end else begin
                  payload_o <= shreg;
                  valid_o   <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            // A stuck-low line must go high before another start edge can be seen.
            S_BREAK: if (rx_s) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign idle_o = (state == S_IDLE);

endmodule
